// File: rtl/lo_pkg.sv
// Shared types and constants for the lights-out game sequencer.
package lo_pkg;

    localparam int unsigned BOARD_DIM   = 8;
    localparam int unsigned BOARD_CELLS = BOARD_DIM * BOARD_DIM;
    localparam int unsigned POS_W       = 3;
    localparam int unsigned LFSR_W      = 16;
    localparam int unsigned BCD_DIGITS  = 4;
    localparam int unsigned BCD_W       = 16;

    // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SCRAMBLE = 2'd0,
        PLAY     = 2'd1,
        WON      = 2'd2
    } lo_state_t;

    typedef logic [3:0] bcd_digit_t;

    // One shift of the scrambler LFSR
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lights_out_ctrl_bcd.sv
// Four-digit wrapping BCD move counter with synchronous clear.
module bcd_counter4
    import lo_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [BCD_W-1:0] bcd
);

    logic [BCD_W-1:0] bcd_nxt;
    logic             carry;
    bcd_digit_t       dig;

    // Ripple the increment through the digits, wrapping each at 9
    always_comb begin
        bcd_nxt = bcd;
        carry   = inc;
        dig     = '0;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            dig = bcd[i*4 +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    dig = '0;
                end else begin
                    dig   = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            bcd_nxt[i*4 +: 4] = dig;
        end
        if (clear) begin
            bcd_nxt = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= '0;
        end else begin
            bcd <= bcd_nxt;
        end
    end

endmodule

// File: rtl/lights_out_ctrl.sv
// Lights-out game sequencer: board, cursor, scrambler LFSR and move counter.
module lights_out_ctrl
    import lo_pkg::*;
#(
    parameter int unsigned       SCRAMBLE_PRESSES = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED        = 16'hACE1
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             enter,
    input  logic             new_game,
    input  logic [POS_W-1:0] row_sel,
    output logic [BOARD_DIM-1:0] row_bits,
    output logic [POS_W-1:0] posx,
    output logic [POS_W-1:0] posy,
    output logic [BCD_W-1:0] bcd,
    output logic             busy,
    output logic             gameover
);

    localparam int unsigned CNT_W = 8;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(BOARD_DIM - 1);

    lo_state_t                state, state_nxt;
    logic [BOARD_CELLS-1:0]   board, board_nxt, toggle, press_sel;
    logic [POS_W-1:0]         posx_nxt, posy_nxt, press_x, press_y;
    logic [LFSR_W-1:0]        lfsr;
    logic [CNT_W-1:0]         press_cnt, press_cnt_nxt;
    logic                     press_en, board_clr, bcd_clr, bcd_inc, board_zero;

    assign board_zero = (board == '0);

    // Next-state, cursor and press decisions
    always_comb begin
        state_nxt     = state;
        posx_nxt      = posx;
        posy_nxt      = posy;
        press_cnt_nxt = press_cnt;
        press_x       = posx;
        press_y       = posy;
        press_en      = 1'b0;
        board_clr     = 1'b0;
        bcd_clr       = 1'b0;
        bcd_inc       = 1'b0;
        if (new_game) begin
            state_nxt     = SCRAMBLE;
            posx_nxt      = '0;
            posy_nxt      = '0;
            press_cnt_nxt = '0;
            board_clr     = 1'b1;
            bcd_clr       = 1'b1;
        end else begin
            case (state)
                SCRAMBLE: begin
                    press_x = lfsr[5:3];
                    press_y = lfsr[2:0];
                    if (press_cnt < CNT_W'(SCRAMBLE_PRESSES)) begin
                        press_en      = 1'b1;
                        press_cnt_nxt = press_cnt + CNT_W'(1);
                    end else if (board_zero) begin
                        press_en = 1'b1;
                    end else begin
                        state_nxt = PLAY;
                    end
                end
                PLAY: begin
                    if (board_zero) begin
                        state_nxt = WON;
                    end else if (tick) begin
                        if (up && !down) begin
                            if (posx != '0) posx_nxt = posx - POS_W'(1);
                        end else if (down && !up) begin
                            if (posx != POS_MAX) posx_nxt = posx + POS_W'(1);
                        end
                        if (left && !right) begin
                            if (posy != '0) posy_nxt = posy - POS_W'(1);
                        end else if (right && !left) begin
                            if (posy != POS_MAX) posy_nxt = posy + POS_W'(1);
                        end
                        if (enter) begin
                            press_en = 1'b1;
                            bcd_inc  = 1'b1;
                        end
                    end
                end
                WON: begin
                    state_nxt = WON;
                end
                default: begin
                    state_nxt = SCRAMBLE;
                end
            endcase
        end
    end

    // One-hot of the pressed cell, index {x,y}
    always_comb begin
        press_sel = '0;
        press_sel[{press_x, press_y}] = press_en;
    end

    // Each cell toggles when any existing orthogonal neighbour is pressed
    for (genvar gi = 0; gi < int'(BOARD_DIM); gi++) begin : g_row
        for (genvar gj = 0; gj < int'(BOARD_DIM); gj++) begin : g_col
            logic n_xm, n_xp, n_ym, n_yp;
            if (gi > 0) begin : g_xm
                assign n_xm = press_sel[(gi-1)*int'(BOARD_DIM) + gj];
            end else begin : g_xm0
                assign n_xm = 1'b0;
            end
            if (gi < int'(BOARD_DIM) - 1) begin : g_xp
                assign n_xp = press_sel[(gi+1)*int'(BOARD_DIM) + gj];
            end else begin : g_xp0
                assign n_xp = 1'b0;
            end
            if (gj > 0) begin : g_ym
                assign n_ym = press_sel[gi*int'(BOARD_DIM) + gj - 1];
            end else begin : g_ym0
                assign n_ym = 1'b0;
            end
            if (gj < int'(BOARD_DIM) - 1) begin : g_yp
                assign n_yp = press_sel[gi*int'(BOARD_DIM) + gj + 1];
            end else begin : g_yp0
                assign n_yp = 1'b0;
            end
            assign toggle[gi*int'(BOARD_DIM) + gj] = n_xm | n_xp | n_ym | n_yp;
        end
    end

    assign board_nxt = board_clr ? '0 : (board ^ toggle);

    // State register with registered status decodes
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SCRAMBLE;
            busy     <= 1'b1;
            gameover <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt == SCRAMBLE);
            gameover <= (state_nxt == WON);
        end
    end

    // Board, cursor, scramble count and free-running LFSR
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            board     <= '0;
            posx      <= '0;
            posy      <= '0;
            press_cnt <= '0;
            lfsr      <= LFSR_SEED;
        end else begin
            board     <= board_nxt;
            posx      <= posx_nxt;
            posy      <= posy_nxt;
            press_cnt <= press_cnt_nxt;
            lfsr      <= lfsr_step(lfsr);
        end
    end

    // Column read for the matrix scanner: bit x = board[x][row_sel]
    always_comb begin
        row_bits = '0;
        for (int x = 0; x < int'(BOARD_DIM); x++) begin
            row_bits[x] = board[{3'(x), row_sel}];
        end
    end

    bcd_counter4 u_bcd (
        .clk   (CLK),
        .rst_n (rst_n),
        .clear (bcd_clr),
        .inc   (bcd_inc),
        .bcd   (bcd)
    );

endmodule

// File: tb/tb_lights_out_ctrl.sv
// Directed bench for lights_out_ctrl with a small board/LFSR reference model.
module tb_lights_out_ctrl;

    localparam int          NPRESS = 16;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic        CLK, rst_n, tick, up, down, left, right, enter, new_game;
    logic [2:0]  row_sel, posx, posy;
    logic [7:0]  row_bits;
    logic [15:0] bcd;
    logic        busy, gameover;

    int total = 0;
    int bad   = 0;

    logic [15:0] mlfsr;
    logic [63:0] bm;
    int          mx, my, mcount;
    int          sx[$];
    int          sy[$];

    lights_out_ctrl #(.SCRAMBLE_PRESSES(NPRESS), .LFSR_SEED(SEED)) dut (
        .CLK(CLK), .rst_n(rst_n), .tick(tick), .up(up), .down(down), .left(left),
        .right(right), .enter(enter), .new_game(new_game), .row_sel(row_sel),
        .row_bits(row_bits), .posx(posx), .posy(posy), .bcd(bcd), .busy(busy),
        .gameover(gameover)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference LFSR: advances on every edge out of reset
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) mlfsr <= SEED;
        else        mlfsr <= lfsr_next(mlfsr);
    end

    function automatic logic [63:0] pmask(input int x, input int y);
        logic [63:0] m;
        m = '0;
        if (x > 0) m[(x-1)*8 + y] = 1'b1;
        if (x < 7) m[(x+1)*8 + y] = 1'b1;
        if (y > 0) m[x*8 + y - 1] = 1'b1;
        if (y < 7) m[x*8 + y + 1] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic read_board(output logic [63:0] b);
        b = '0;
        for (int y = 0; y < 8; y++) begin
            row_sel = 3'(y);
            #1;
            for (int x = 0; x < 8; x++) b[x*8 + y] = row_bits[x];
        end
    endtask

    // Scramble from a given LFSR value: press list and resulting board
    task automatic scr_model(input logic [15:0] s);
        int n;
        bm = '0;
        n  = 0;
        sx.delete();
        sy.delete();
        while ((n < NPRESS || bm == '0) && n < 1000) begin
            sx.push_back(int'(s[5:3]));
            sy.push_back(int'(s[2:0]));
            bm = bm ^ pmask(int'(s[5:3]), int'(s[2:0]));
            s  = lfsr_next(s);
            n++;
        end
        mx = 0; my = 0; mcount = 0;
    endtask

    // One PLAY tick with the given controls; updates the reference
    task automatic move(input logic u, input logic d, input logic l, input logic r, input logic e);
        up = u; down = d; left = l; right = r; enter = e; tick = 1'b1;
        cyc();
        up = 0; down = 0; left = 0; right = 0; enter = 0; tick = 0;
        if (e) begin
            bm     = bm ^ pmask(mx, my);
            mcount = (mcount + 1) % 10000;
        end
        if (u && !d && mx > 0) mx--;
        else if (d && !u && mx < 7) mx++;
        if (l && !r && my > 0) my--;
        else if (r && !l && my < 7) my++;
    endtask

    task automatic wait_scramble(input string tag);
        int n;
        logic [63:0] b;
        n = 0;
        while (busy === 1'b1 && n < 600) begin
            cyc();
            n++;
        end
        total++;
        if (busy !== 1'b0 || n < NPRESS) begin
            bad++;
            $display("FAIL %s scramble_len: busy=%b cycles=%0d want busy=0 cycles>=%0d", tag, busy, n, NPRESS);
        end
        read_board(b);
        total++;
        if (b !== bm) begin bad++; $display("FAIL %s scramble_board: got %h want %h", tag, b, bm); end
        total++;
        if (b === '0) begin bad++; $display("FAIL %s board_nonzero: got %h want nonzero", tag, b); end
        total++;
        if (bcd !== 16'h0000 || posx !== 3'd0 || posy !== 3'd0 || gameover !== 1'b0) begin
            bad++;
            $display("FAIL %s play_entry: bcd=%h pos=(%0d,%0d) go=%b want 0000 (0,0) 0", tag, bcd, posx, posy, gameover);
        end
    endtask

    task automatic test_reset();
        logic [63:0] b;
        rst_n = 0;
        #3;
        read_board(b);
        total++;
        if (busy !== 1'b1 || gameover !== 1'b0 || bcd !== 16'h0 || posx !== 3'd0 || posy !== 3'd0 || b !== '0) begin
            bad++;
            $display("FAIL reset_vals: busy=%b go=%b bcd=%h pos=(%0d,%0d) board=%h want 1 0 0000 (0,0) 0", busy, gameover, bcd, posx, posy, b);
        end
        @(negedge CLK);
        rst_n = 1;
        scr_model(SEED);
        wait_scramble("reset");
    endtask

    task automatic test_move();
        move(1, 0, 1, 0, 0);
        total++;
        if (posx !== 3'd0 || posy !== 3'd0) begin bad++; $display("FAIL move_sat_low: got (%0d,%0d) want (0,0)", posx, posy); end
        for (int i = 0; i < 3; i++) move(0, 1, 0, 1, 0);
        total++;
        if (posx !== 3'd3 || posy !== 3'd3) begin bad++; $display("FAIL move_3_3: got (%0d,%0d) want (3,3)", posx, posy); end
        move(1, 1, 0, 0, 0);
        total++;
        if (posx !== 3'd3 || posy !== 3'd3) begin bad++; $display("FAIL move_both: got (%0d,%0d) want (3,3)", posx, posy); end
        down = 1; right = 1;
        cyc();
        down = 0; right = 0;
        total++;
        if (posx !== 3'd3 || posy !== 3'd3) begin bad++; $display("FAIL move_no_tick: got (%0d,%0d) want (3,3)", posx, posy); end
        for (int i = 0; i < 6; i++) move(0, 1, 0, 1, 0);
        total++;
        if (posx !== 3'd7 || posy !== 3'd7) begin bad++; $display("FAIL move_sat_high: got (%0d,%0d) want (7,7)", posx, posy); end
        for (int i = 0; i < 7; i++) move(1, 0, 1, 0, 0);
        total++;
        if (posx !== 3'd0 || posy !== 3'd0) begin bad++; $display("FAIL move_home: got (%0d,%0d) want (0,0)", posx, posy); end
    endtask

    task automatic test_press();
        logic [63:0] b0, b;
        read_board(b0);
        move(0, 0, 0, 0, 1);
        read_board(b);
        total++;
        if ((b ^ b0) !== ((64'd1 << 8) | (64'd1 << 1))) begin
            bad++; $display("FAIL press_corner: diff %h want %h", b ^ b0, (64'd1 << 8) | (64'd1 << 1));
        end
        total++;
        if (bcd !== 16'h0001) begin bad++; $display("FAIL press_bcd1: got %h want 0001", bcd); end
        move(0, 1, 0, 1, 1);
        read_board(b);
        total++;
        if (b !== b0 || posx !== 3'd1 || posy !== 3'd1 || bcd !== 16'h0002) begin
            bad++; $display("FAIL press_premove: board %h pos (%0d,%0d) bcd %h want %h (1,1) 0002", b, posx, posy, bcd, b0);
        end
        for (int i = 0; i < 6; i++) move(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) move(0, 0, 0, 1, 0);
        move(0, 0, 0, 0, 1);
        read_board(b);
        total++;
        if ((b ^ b0) !== ((64'd1 << 52) | (64'd1 << 59) | (64'd1 << 61)) || bcd !== 16'h0003) begin
            bad++; $display("FAIL press_edge: diff %h bcd %h want %h 0003", b ^ b0, bcd, (64'd1 << 52) | (64'd1 << 59) | (64'd1 << 61));
        end
        enter = 1;
        cyc();
        enter = 0;
        read_board(b);
        total++;
        if (b !== bm || bcd !== 16'h0003) begin bad++; $display("FAIL enter_no_tick: board %h bcd %h want %h 0003", b, bcd, bm); end
    endtask

    task automatic test_bcd();
        logic [63:0] b;
        if ((bm ^ pmask(mx, my)) == '0) move(1, 0, 0, 0, 0);
        while (mcount != 9) move(0, 0, 0, 0, 1);
        total++;
        if (bcd !== 16'h0009) begin bad++; $display("FAIL bcd_9: got %h want 0009", bcd); end
        move(0, 0, 0, 0, 1);
        total++;
        if (bcd !== 16'h0010) begin bad++; $display("FAIL bcd_carry: got %h want 0010", bcd); end
        while (mcount != 9999) move(0, 0, 0, 0, 1);
        total++;
        if (bcd !== 16'h9999) begin bad++; $display("FAIL bcd_9999: got %h want 9999", bcd); end
        move(0, 0, 0, 0, 1);
        read_board(b);
        total++;
        if (bcd !== 16'h0000 || b !== bm) begin bad++; $display("FAIL bcd_wrap: bcd %h board %h want 0000 %h", bcd, b, bm); end
    endtask

    task automatic test_new_game_play();
        logic [63:0] b;
        new_game = 1;
        cyc();
        read_board(b);
        total++;
        if (busy !== 1'b1 || bcd !== 16'h0 || posx !== 3'd0 || posy !== 3'd0 || b !== '0) begin
            bad++; $display("FAIL newgame_play: busy %b bcd %h pos (%0d,%0d) board %h want 1 0000 (0,0) 0", busy, bcd, posx, posy, b);
        end
        cyc();
        read_board(b);
        total++;
        if (busy !== 1'b1 || b !== '0) begin bad++; $display("FAIL newgame_held: busy %b board %h want 1 0", busy, b); end
        new_game = 0;
        scr_model(mlfsr);
        wait_scramble("newgame");
    endtask

    task automatic test_win();
        logic [63:0] b;
        logic        won;
        int          tx, ty;
        won = 0;
        for (int i = 0; i < sx.size() && !won; i++) begin
            tx = sx[i];
            ty = sy[i];
            for (int k = 0; k < 8 && (mx != tx || my != ty); k++)
                move(mx > tx, mx < tx, my > ty, my < ty, 0);
            move(0, 0, 0, 0, 1);
            if (bm == '0) begin
                won = 1;
                total++;
                if (gameover !== 1'b0) begin bad++; $display("FAIL win_latency: gameover %b want 0 on press edge", gameover); end
                cyc();
                total++;
                if (gameover !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL win_gameover: go %b busy %b want 1 0", gameover, busy); end
            end
        end
        total++;
        if (!won) begin bad++; $display("FAIL win_reached: board %h want 0", bm); end
        tick = 1; enter = 1; down = 1; right = 1;
        cyc();
        tick = 0; enter = 0; down = 0; right = 0;
        read_board(b);
        total++;
        if (b !== '0 || posx !== 3'(mx) || posy !== 3'(my) || bcd !== to_bcd(mcount) || gameover !== 1'b1) begin
            bad++; $display("FAIL won_frozen: board %h pos (%0d,%0d) bcd %h go %b want 0 (%0d,%0d) %h 1", b, posx, posy, bcd, gameover, mx, my, to_bcd(mcount));
        end
    endtask

    task automatic test_new_game_won();
        new_game = 1;
        cyc();
        total++;
        if (busy !== 1'b1 || gameover !== 1'b0 || bcd !== 16'h0 || posx !== 3'd0 || posy !== 3'd0) begin
            bad++; $display("FAIL newgame_won: busy %b go %b bcd %h pos (%0d,%0d) want 1 0 0000 (0,0)", busy, gameover, bcd, posx, posy);
        end
        new_game = 0;
        scr_model(mlfsr);
        wait_scramble("newgame_won");
    endtask

    task automatic test_reset_mid();
        logic [63:0] b;
        move(0, 1, 0, 1, 1);
        move(0, 1, 0, 1, 0);
        #2 rst_n = 0;
        #1;
        total++;
        if (busy !== 1'b1 || gameover !== 1'b0 || bcd !== 16'h0 || posx !== 3'd0 || posy !== 3'd0) begin
            bad++; $display("FAIL reset_mid_play: busy %b go %b bcd %h pos (%0d,%0d) want 1 0 0000 (0,0)", busy, gameover, bcd, posx, posy);
        end
        read_board(b);
        total++;
        if (b !== '0) begin bad++; $display("FAIL reset_mid_play_board: got %h want 0", b); end
        @(negedge CLK);
        rst_n = 1;
        cyc(); cyc(); cyc();
        #2 rst_n = 0;
        #1;
        read_board(b);
        total++;
        if (busy !== 1'b1 || b !== '0 || bcd !== 16'h0) begin
            bad++; $display("FAIL reset_mid_scramble: busy %b board %h bcd %h want 1 0 0000", busy, b, bcd);
        end
        @(negedge CLK);
        rst_n = 1;
        scr_model(SEED);
        wait_scramble("reset_again");
    endtask

    initial begin
        rst_n = 0; tick = 0; up = 0; down = 0; left = 0; right = 0;
        enter = 0; new_game = 0; row_sel = '0;
        test_reset();
        test_move();
        test_press();
        test_bcd();
        test_new_game_play();
        test_win();
        test_new_game_won();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
